// File: rtl/mealy_multi_pattern_detector.sv
// Serial Mealy detector for two PAT_W-bit patterns with saturating per-pattern match counters.
// Optional PATTERN_PROG_EN macro adds runtime-writable pattern registers (pat_wr/pat_sel/pat_data).
module mealy_multi_pattern_detector #(
    parameter int                 PAT_W = 3,
    parameter logic [PAT_W-1:0]   PAT_A = 3'b110,
    parameter logic [PAT_W-1:0]   PAT_B = 3'b001,
    parameter int                 CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic             i,
    input  logic             clear,
    input  logic             overlap,
`ifdef PATTERN_PROG_EN
    input  logic             pat_wr,
    input  logic             pat_sel,
    input  logic [PAT_W-1:0] pat_data,
`endif
    output logic [1:0]       o,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-2:0] hist, hist_nxt;
    logic [FW-1:0]    fill, fill_nxt;
    logic [CNT_W-1:0] cnt_a_nxt, cnt_b_nxt;
    logic [PAT_W-1:0] win;
    logic [PAT_W-1:0] pat_a, pat_b;
    logic             armed;

`ifdef PATTERN_PROG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_a <= PAT_A;
            pat_b <= PAT_B;
        end else if (pat_wr) begin
            if (pat_sel) pat_b <= pat_data;
            else         pat_a <= pat_data;
        end
    end
`else
    assign pat_a = PAT_A;
    assign pat_b = PAT_B;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist  <= '0;
            fill  <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            hist  <= hist_nxt;
            fill  <= fill_nxt;
            cnt_a <= cnt_a_nxt;
            cnt_b <= cnt_b_nxt;
        end
    end

    always_comb begin
        o         = '0;
        hist_nxt  = hist;
        fill_nxt  = fill;
        cnt_a_nxt = cnt_a;
        cnt_b_nxt = cnt_b;
        win       = {hist, i};
        armed     = i_valid && (fill == FILL_MAX) && !clear;

        // A is tested first so identical patterns report and count as A only
        if (armed && (win == pat_a))      o = 2'd2;
        else if (armed && (win == pat_b)) o = 2'd1;

        if (clear) begin
            hist_nxt  = '0;
            fill_nxt  = '0;
            cnt_a_nxt = '0;
            cnt_b_nxt = '0;
        end else if (i_valid) begin
            if ((o != 2'd0) && !overlap) begin
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                // low PAT_W-1 bits of the window are the shifted history, also for PAT_W=2
                hist_nxt = win[PAT_W-2:0];
                if (fill != FILL_MAX) fill_nxt = fill + 1'b1;
            end
            if ((o == 2'd2) && (cnt_a != '1)) cnt_a_nxt = cnt_a + 1'b1;
            if ((o == 2'd1) && (cnt_b != '1)) cnt_b_nxt = cnt_b + 1'b1;
        end
    end

endmodule
